// File: rtl/dsp_imem_arbiter_pkg.sv
// Shared definitions for the DSP instruction-memory arbiter: widths, owner tags, NOP word.
package dsp_imem_arbiter_pkg;

  localparam int unsigned MEM_ADDR_LEN  = 16;
  localparam int unsigned INST_WORD_LEN = 32;
  localparam int unsigned STARVE_W      = 8;

  localparam logic [INST_WORD_LEN-1:0] NOP_WORD = '0;

  // Who owns the read data returning from the RAM this cycle.
  typedef enum logic [1:0] {
    OwnNone  = 2'd0,
    OwnFetch = 2'd1,
    OwnDbg   = 2'd2
  } owner_e;

endpackage

// File: rtl/dsp_starve_counter.sv
// Saturating starvation counter with synchronous clear; sat flags the forced-fetch cycle.
module dsp_starve_counter
  import dsp_imem_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [STARVE_W-1:0] LimitC = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LimitC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == LimitC);

endmodule

// File: rtl/dsp_imem_arbiter.sv
// Arbitrates the single-port instruction RAM between fetch (read), loader (write) and debug
// (read), tags returning read data with its owner and guards fetch against starvation.
module dsp_imem_arbiter #(
  parameter int unsigned ADDR_W       = dsp_imem_arbiter_pkg::MEM_ADDR_LEN,
  parameter int unsigned DATA_W       = dsp_imem_arbiter_pkg::INST_WORD_LEN,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(dsp_imem_arbiter_pkg::NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_stall,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              fetch_valid,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import dsp_imem_arbiter_pkg::*;

  logic        forced;
  logic        ld_grant, dbg_grant, fetch_grant;
  owner_e      rd_owner_d, rd_owner_q;
  logic [DATA_W-1:0] dbg_data_q;

  dsp_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (fetch_en & ~fetch_grant & ~rst),
    .clr (rst | ~fetch_en | fetch_grant),
    .sat (forced)
  );

  // Normal priority ld > dbg > fetch; a saturated starve counter lets fetch win once.
  always_comb begin
    ld_grant    = 1'b0;
    dbg_grant   = 1'b0;
    fetch_grant = 1'b0;
    if (!rst) begin
      if (forced && fetch_en) begin
        fetch_grant = 1'b1;
      end else if (ld_req) begin
        ld_grant = 1'b1;
      end else if (dbg_req) begin
        dbg_grant = 1'b1;
      end else if (fetch_en) begin
        fetch_grant = 1'b1;
      end
    end
  end

  // A fetch read issued under flush used the stale PC, so it is never tagged.
  always_comb begin
    rd_owner_d = OwnNone;
    if (rst) begin
      rd_owner_d = OwnNone;
    end else if (fetch_grant && !fetch_flush) begin
      rd_owner_d = OwnFetch;
    end else if (dbg_grant) begin
      rd_owner_d = OwnDbg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_q <= OwnNone;
      dbg_data_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      if (dbg_valid) begin
        dbg_data_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_en    = ld_grant | dbg_grant | fetch_grant;
    mem_we    = ld_grant;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_grant) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else if (dbg_grant) begin
      mem_addr = dbg_addr;
    end else if (fetch_grant) begin
      mem_addr = fetch_addr;
    end
  end

  assign ld_ack      = ld_grant;
  assign dbg_ack     = dbg_grant;
  assign fetch_stall = rst | (fetch_en & ~fetch_grant);

  // A flush in the return cycle also drops the word arriving now.
  assign fetch_valid = ~rst & (rd_owner_q == OwnFetch) & ~fetch_flush;
  assign fetch_inst  = fetch_valid ? mem_rdata : NOP_WORD;
  assign dbg_valid   = ~rst & (rd_owner_q == OwnDbg);
  assign dbg_data    = dbg_valid ? mem_rdata : dbg_data_q;

endmodule

// File: tb/tb_dsp_imem_arbiter.sv
// Directed bench for dsp_imem_arbiter with a small RAM fixture and a read-return scoreboard.
module tb_dsp_imem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en, fetch_flush, ld_req, dbg_req;
  logic [AW-1:0] fetch_addr, ld_addr, dbg_addr;
  logic [DW-1:0] ld_data;
  logic          fetch_stall, fetch_valid, ld_ack, dbg_ack, dbg_valid;
  logic [DW-1:0] fetch_inst, dbg_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] ram [256];

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  logic [DW-1:0] exp_fetch[$];
  logic [DW-1:0] exp_dbg[$];

  dsp_imem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (8),
    .NOP_WORD     ('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_flush (fetch_flush),
    .fetch_stall (fetch_stall),
    .fetch_inst  (fetch_inst),
    .fetch_valid (fetch_valid),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ack      (ld_ack),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_ack     (dbg_ack),
    .dbg_data    (dbg_data),
    .dbg_valid   (dbg_valid),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 + i;
  end

  // Single-port synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_en = 0; fetch_flush = 0; ld_req = 0; dbg_req = 0;
  endtask

  // Scoreboard monitor: every valid must match the oldest expected word of its owner.
  always @(negedge clk) begin
    if (mon_on) begin
      if (fetch_valid) begin
        if (exp_fetch.size() == 0) begin
          total++; bad++;
          $display("FAIL fetch_unexpected: got %h expected no valid at %0t", fetch_inst, $time);
        end else begin
          chk("fetch_inst", fetch_inst, exp_fetch.pop_front());
        end
      end else begin
        chk("fetch_nop", fetch_inst, '0);
      end
      if (dbg_valid) begin
        if (exp_dbg.size() == 0) begin
          total++; bad++;
          $display("FAIL dbg_unexpected: got %h expected no valid at %0t", dbg_data, $time);
        end else begin
          chk("dbg_data", dbg_data, exp_dbg.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1; idle();
    fetch_addr = '0; ld_addr = '0; dbg_addr = '0; ld_data = '0;
    adv();
    mon_on = 1'b1;
    // Reset gates every request.
    fetch_en = 1; ld_req = 1; dbg_req = 1;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_ld_ack", ld_ack, 0);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_stall", fetch_stall, 1);
    chk("rst_fvalid", fetch_valid, 0);
    chk("rst_dbg_data", dbg_data, 0);
    adv();
    rst = 0; idle();

    // Fetch only, addresses 0..3.
    for (int a = 0; a < 4; a++) begin
      fetch_en = 1; fetch_addr = AW'(a);
      @(negedge clk);
      chk("f_stall", fetch_stall, 0);
      chk("f_mem_en", mem_en, 1);
      chk("f_mem_we", mem_we, 0);
      chk("f_mem_addr", DW'(mem_addr), DW'(a));
      exp_fetch.push_back(32'hA000_0000 + a);
      adv();
    end
    idle();
    adv();

    // Loader write beats fetch.
    ld_req = 1; ld_addr = 16'h0010; ld_data = 32'hDEAD_BEEF; fetch_en = 1; fetch_addr = 16'h4;
    @(negedge clk);
    chk("ld_we", mem_we, 1);
    chk("ld_ack", ld_ack, 1);
    chk("ld_stall", fetch_stall, 1);
    chk("ld_addr", DW'(mem_addr), 32'h10);
    chk("ld_wdata", mem_wdata, 32'hDEAD_BEEF);
    adv();
    ld_req = 0;
    @(negedge clk);
    chk("after_ld_fvalid", fetch_valid, 0);
    chk("after_ld_stall", fetch_stall, 0);
    exp_fetch.push_back(32'hA000_0004);
    adv();

    // Starvation guard: 8 lost cycles, then one forced fetch win.
    ld_req = 1; ld_addr = 16'h0030; ld_data = 32'h1111_1111;
    dbg_req = 1; dbg_addr = 16'h0031; fetch_en = 1; fetch_addr = 16'h5;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 8) begin
        chk("starve_stall", fetch_stall, 0);
        chk("starve_ld_ack", ld_ack, 0);
        chk("starve_dbg_ack", dbg_ack, 0);
        chk("starve_addr", DW'(mem_addr), 32'h5);
        exp_fetch.push_back(32'hA000_0005);
      end else begin
        chk("starve_lose", fetch_stall, 1);
        chk("starve_ld_win", ld_ack, 1);
        chk("starve_dbg_lose", dbg_ack, 0);
      end
      adv();
    end
    idle();
    adv();

    // Flush: in-flight fetch word dropped, debug read alongside survives.
    fetch_en = 1; fetch_addr = 16'h6;
    adv();
    fetch_flush = 1; fetch_addr = 16'h7; dbg_req = 1; dbg_addr = 16'h0002;
    @(negedge clk);
    chk("fl_dbg_ack", dbg_ack, 1);
    chk("fl_fvalid", fetch_valid, 0);
    exp_dbg.push_back(32'hA000_0002);
    adv();
    dbg_req = 0; fetch_addr = 16'h8;
    @(negedge clk);
    chk("fl_grant", fetch_stall, 0);
    adv();
    idle();
    adv();

    // Same-address collision: loader wins, debug then reads the new word.
    ld_req = 1; ld_addr = 16'h0020; ld_data = 32'h1234_5678; dbg_req = 1; dbg_addr = 16'h0020;
    @(negedge clk);
    chk("col_ld_ack", ld_ack, 1);
    chk("col_dbg_ack", dbg_ack, 0);
    adv();
    ld_req = 0;
    @(negedge clk);
    chk("col_dbg_ack2", dbg_ack, 1);
    exp_dbg.push_back(32'h1234_5678);
    adv();
    idle();
    adv();
    @(negedge clk);
    chk("dbg_hold", dbg_data, 32'h1234_5678);
    chk("dbg_hold_valid", dbg_valid, 0);
    adv();

    // Reset with a fetch read in flight and requests pending.
    fetch_en = 1; fetch_addr = 16'h9;
    adv();
    rst = 1; ld_req = 1; ld_addr = 16'h0030; dbg_req = 1; dbg_addr = 16'h0031;
    @(negedge clk);
    chk("r2_mem_en", mem_en, 0);
    chk("r2_ld_ack", ld_ack, 0);
    chk("r2_dbg_ack", dbg_ack, 0);
    chk("r2_stall", fetch_stall, 1);
    chk("r2_fvalid", fetch_valid, 0);
    adv();
    @(negedge clk);
    chk("r2b_fvalid", fetch_valid, 0);
    chk("r2b_dvalid", dbg_valid, 0);
    chk("r2b_dbg_data", dbg_data, 0);
    adv();
    rst = 0;
    @(negedge clk);
    chk("rel_ld_ack", ld_ack, 1);
    chk("rel_mem_en", mem_en, 1);
    chk("rel_fvalid", fetch_valid, 0);
    chk("rel_dvalid", dbg_valid, 0);
    adv();
    ld_req = 0;
    @(negedge clk);
    chk("rel_dbg_ack", dbg_ack, 1);
    exp_dbg.push_back(32'hA000_0031);
    adv();
    idle();
    adv();
    adv();

    chk("fetch_q_drained", DW'(exp_fetch.size()), 0);
    chk("dbg_q_drained", DW'(exp_dbg.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
